// File: rtl/d_detect_handler.sv
// d_detect_handler
//   Services detections from the sequence detector. Each detection raises
//   the alarm for HOLD cycles and bumps a saturating counter. It then pulses
//   en to release the detector and confirms that w has dropped. If w is still
//   high after RETRY cycles, en is pulsed again and the sticky error is set.
//
// Ports
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   w_i       detection flag (level) from the detector
//   clr_i     synchronous clear of count_o and err_o
//   en_o      release pulse to the detector (one cycle per acknowledge)
//   alarm_o   high while a detection is being serviced
//   busy_o    high whenever the FSM is not idle
//   count_o   saturating number of accepted detections
//   err_o     sticky: detector did not drop w after an acknowledge
//
// state  | meaning
// S_IDLE | waiting for w
// S_HOLD | alarm hold time running, w ignored
// S_ACK  | en high for one cycle
// S_WAIT | checking that the detector dropped w
module d_detect_handler #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8,
    parameter int RETRY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             w_i,
    input  logic             clr_i,
    output logic             en_o,
    output logic             alarm_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ACK, S_WAIT} state_t;

    localparam logic [7:0]       HOLD_LD = 8'(HOLD - 1);
    localparam logic [3:0]       RETRY_L = 4'(RETRY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       retry_q, retry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             en_q, alarm_q, busy_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        retry_d = retry_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_i) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LD;
                    if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (hold_q == 8'd0) state_d = S_ACK;
                else                hold_d  = hold_q - 8'd1;
            end
            S_ACK: begin
                state_d = S_WAIT;
                retry_d = 4'd0;
            end
            S_WAIT: begin
                if (!w_i) begin
                    state_d = S_IDLE;
                end else begin
                    retry_d = retry_q + 4'd1;
                    if (retry_q + 4'd1 == RETRY_L) begin
                        state_d = S_ACK;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Clear wins over a same-cycle increment or error set.
        if (clr_i) begin
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    // Outputs are registered from the next state, so they equal a decode of
    // the current state without any input-to-output path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hold_q  <= 8'd0;
            retry_q <= 4'd0;
            count_q <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            retry_q <= retry_d;
            count_q <= count_d;
            err_q   <= err_d;
            en_q    <= (state_d == S_ACK);
            alarm_q <= (state_d == S_HOLD) || (state_d == S_ACK) || (state_d == S_WAIT);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign en_o    = en_q;
    assign alarm_o = alarm_q;
    assign busy_o  = busy_q;
    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_d_detect_handler.sv
module tb_d_detect_handler;

    localparam int HOLD  = 4;
    localparam int CNT_W = 3;
    localparam int RETRY = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             w_i   = 1'b0;
    logic             clr_i = 1'b0;
    logic             en_o, alarm_o, busy_o, err_o;
    logic [CNT_W-1:0] count_o;

    d_detect_handler #(.HOLD(HOLD), .CNT_W(CNT_W), .RETRY(RETRY)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .w_i(w_i), .clr_i(clr_i),
        .en_o(en_o), .alarm_o(alarm_o), .busy_o(busy_o),
        .count_o(count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;
    int en_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Timestamp model: a service starts at the accepting edge, en is due
    // HOLD edges later, then w is watched for up to RETRY edges after en.
    bit m_active;
    int m_count, m_err, m_e, m_tack;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_active = 1'b0; m_count = 0; m_err = 0; m_e = 0; m_tack = -10;
        end else begin
            m_e++;
            if (!m_active) begin
                if (w_i) begin
                    m_active = 1'b1;
                    m_tack   = m_e + HOLD;
                    if (m_count < CMAX) m_count++;
                end
            end else if (m_e > m_tack + 1) begin
                if (!w_i) m_active = 1'b0;
                else if (m_e - m_tack - 1 == RETRY) begin
                    m_tack = m_e;
                    m_err  = 1;
                end
            end
            if (clr_i) begin
                m_count = 0;
                m_err   = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (en_o) en_seen++;
        if (chk_on && !rst_i) begin
            chk("cyc_alarm", int'(alarm_o), int'(m_active));
            chk("cyc_busy",  int'(busy_o),  int'(m_active));
            chk("cyc_en",    int'(en_o),    int'(m_active && m_e == m_tack));
            chk("cyc_count", int'(count_o), m_count);
            chk("cyc_err",   int'(err_o),   m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // One nominal detection: detector releases the cycle after seeing en.
    task automatic detect_once(input int exp_cnt, input string name);
        w_i = 1'b1;
        tick(1);
        chk(name, int'(count_o), exp_cnt);
        tick(HOLD);
        tick(1);
        w_i = 1'b0;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        // Reset values
        rst_i = 1'b1;
        tick(3);
        rst_i = 1'b0;
        #1;
        chk("rst_en", int'(en_o), 0);
        chk("rst_alarm", int'(alarm_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk_on = 1'b1;

        // Single nominal detection
        w_i = 1'b1;
        tick(1);
        chk("t2_alarm_k", int'(alarm_o), 1);
        chk("t2_en_k", int'(en_o), 0);
        chk("t2_count_k", int'(count_o), 1);
        chk("t2_model_count", m_count, 1);
        tick(HOLD - 1);
        chk("t2_en_k3", int'(en_o), 0);
        tick(1);
        chk("t2_en_k4", int'(en_o), 1);
        chk("t2_model_en", int'(m_e == m_tack), 1);
        tick(1);
        chk("t2_en_k5", int'(en_o), 0);
        chk("t2_busy_k5", int'(busy_o), 1);
        w_i = 1'b0;
        tick(1);
        chk("t2_busy_k6", int'(busy_o), 0);
        chk("t2_alarm_k6", int'(alarm_o), 0);
        chk("t2_count_k6", int'(count_o), 1);
        chk("t2_err_k6", int'(err_o), 0);

        // Async reset in the middle of the hold time
        w_i = 1'b1;
        tick(2);
        chk("t1_busy_mid", int'(busy_o), 1);
        #1 rst_i = 1'b1;
        #1;
        chk("t1_arst_alarm", int'(alarm_o), 0);
        chk("t1_arst_busy", int'(busy_o), 0);
        chk("t1_arst_count", int'(count_o), 0);
        chk("t1_arst_en", int'(en_o), 0);
        w_i = 1'b0;
        tick(1);
        rst_i = 1'b0;
        tick(1);

        // Stuck detector
        w_i = 1'b1;
        tick(1);
        chk("t3_count", int'(count_o), 1);
        tick(HOLD);
        chk("t3_en1", int'(en_o), 1);
        chk("t3_err0", int'(err_o), 0);
        tick(RETRY);
        chk("t3_en_w", int'(en_o), 0);
        chk("t3_err_w", int'(err_o), 0);
        tick(1);
        chk("t3_en2", int'(en_o), 1);
        chk("t3_err1", int'(err_o), 1);
        tick(RETRY + 1);
        chk("t3_en3", int'(en_o), 1);
        chk("t3_count_hold", int'(count_o), 1);
        w_i = 1'b0;
        tick(2);
        chk("t3_idle", int'(busy_o), 0);
        chk("t3_err_sticky", int'(err_o), 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        chk("t3_clr_err", int'(err_o), 0);
        chk("t3_clr_count", int'(count_o), 0);

        // Saturation at 7 with a 3-bit counter
        for (int i = 1; i <= 9; i++) detect_once((i > CMAX) ? CMAX : i, "t4_sat");
        chk("t4_final", int'(count_o), 7);

        // clr collides with the accepting edge
        w_i   = 1'b1;
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        chk("t5_count0", int'(count_o), 0);
        chk("t5_busy", int'(busy_o), 1);
        tick(HOLD + 1);
        w_i = 1'b0;
        tick(1);
        detect_once(1, "t5_next");

        // Back-to-back detections, detector re-arms 3 cycles after release
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        base = en_seen;
        w_i  = 1'b1;
        tick(HOLD + 2);
        w_i = 1'b0;
        tick(3);
        w_i = 1'b1;
        tick(1);
        chk("t6_count2", int'(count_o), 2);
        chk("t6_busy", int'(busy_o), 1);
        tick(HOLD + 1);
        w_i = 1'b0;
        tick(2);
        chk("t6_idle", int'(busy_o), 0);
        chk("t6_en_pulses", en_seen - base, 2);
        chk("t6_err", int'(err_o), 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
